band_mix_scheduler: RTL

Time-multiplexes one shared sample-ROM read port across NUM_BANDS equal-length band tables, so one BRAM replaces a bank of per-band playback instances. On each 44 kHz `enable` strobe it reads the current sample of every band and scales each sample by a per-band gain. It then accumulates, saturates and emits one 16-bit mixed sample with a one-cycle `valid_out`. It sits between the concatenated band ROM and the audio output path, in the 4.4 MHz domain.

---
 rtl/band_pkg.sv | 25 ++
 rtl/band_mix_mac.sv | 56 +++++
 rtl/band_mix_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/band_pkg.sv
// ============================================================================
// Module      : band_pkg
// Description : Shared widths, gain constants and FSM state type for the
//               band mix scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package band_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W = 8;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'd128;
  localparam int GAIN_SHIFT = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/band_mix_mac.sv
// ============================================================================
// Module      : band_mix_mac
// Description : Signed sample x unsigned Q1.7 gain multiply-accumulate with
//               clear, plus a Q1.7 rescale and 16-bit saturation of the sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module band_mix_mac
  import band_pkg::*;
#(
  parameter int ACC_W = SAMPLE_W + GAIN_W + 1 + 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       acc_en,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [SAMPLE_W-1:0] mix
);

  localparam int c_prod_w = SAMPLE_W + GAIN_W + 1;
  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-(2 ** (SAMPLE_W - 1)));

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_shift;

  // Gain is zero-extended so 255 stays positive in the signed multiply.
  assign w_prod  = sample * $signed({1'b0, gain});
  assign w_shift = r_acc >>> GAIN_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (acc_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  always_comb begin
    mix = w_shift[SAMPLE_W-1:0];
    if (w_shift > c_sat_max) begin
      mix = c_sat_max[SAMPLE_W-1:0];
    end else if (w_shift < c_sat_min) begin
      mix = c_sat_min[SAMPLE_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/band_mix_scheduler.sv
// ============================================================================
// Module      : band_mix_scheduler
// Description : Per-frame sweep of NUM_BANDS tables through one ROM port,
//               gain-weighted mix into a single saturated 16-bit sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module band_mix_scheduler
  import band_pkg::*;
#(
  parameter int NUM_BANDS  = 16,
  parameter int BAND_DEPTH = 4036,
  parameter int ADDR_WIDTH = $clog2(NUM_BANDS * BAND_DEPTH),
  parameter int BAND_W     = $clog2(NUM_BANDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  gain_we,
  input  logic [BAND_W-1:0]     gain_band,
  input  logic [GAIN_W-1:0]     gain_val,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [SAMPLE_W-1:0]   rom_dout,
  output logic [SAMPLE_W-1:0]   mix_out,
  output logic                  valid_out,
  output logic                  overrun
);

  localparam int c_acc_w = SAMPLE_W + GAIN_W + 1 + BAND_W;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic [BAND_W-1:0]       r_band_idx;
  logic [BAND_W-1:0]       r_mac_band;
  logic                    r_acc_en;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [GAIN_W-1:0]       r_gain_pend [NUM_BANDS];
  logic [GAIN_W-1:0]       r_gain_act  [NUM_BANDS];
  logic signed [SAMPLE_W-1:0] w_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    rom_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_accept    = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        rom_en = 1'b1;
        if (r_band_idx == BAND_W'(NUM_BANDS - 1)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN:   w_state_nxt = OUTPUT;
      OUTPUT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rom_addr = rom_en ? (r_base + r_ptr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_band_idx <= '0;
      r_mac_band <= '0;
      r_acc_en   <= 1'b0;
      r_base     <= '0;
      r_ptr      <= '0;
      mix_out    <= '0;
      valid_out  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      // ROM data lags the address by one cycle, so the MAC follows the issue.
      r_acc_en   <= rom_en;
      r_mac_band <= r_band_idx;
      if (w_accept) begin
        r_band_idx <= '0;
        r_base     <= '0;
      end else if (rom_en) begin
        r_band_idx <= r_band_idx + 1'b1;
        r_base     <= r_base + ADDR_WIDTH'(BAND_DEPTH);
      end
      if (enable && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (r_state == OUTPUT) begin
        mix_out   <= w_mix;
        valid_out <= 1'b1;
        r_ptr     <= (r_ptr == ADDR_WIDTH'(BAND_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  // Pending bank absorbs writes at any time; active bank only loads at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_gain_pend[b] <= GAIN_UNITY;
        r_gain_act[b]  <= GAIN_UNITY;
      end
    end else begin
      if (w_accept) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          r_gain_act[b] <= r_gain_pend[b];
        end
      end
      if (gain_we) begin
        r_gain_pend[gain_band] <= gain_val;
      end
    end
  end

  band_mix_mac #(
    .ACC_W (c_acc_w)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_accept),
    .acc_en (r_acc_en),
    .sample (rom_dout),
    .gain   (r_gain_act[r_mac_band]),
    .mix    (w_mix)
  );

endmodule

`default_nettype wire
